// File: rtl/io_stall_controller.sv
// Stalls the single-cycle datapath around IN (wait for a debounced ENTER press and release)
// and PRINT (latch a display value, then hold for a fixed number of cycles).
module io_stall_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRINT_STALL     = 2,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned SW_W            = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic              print_req,
    input  logic [DATA_W-1:0] print_value,
    input  logic              enter,
    input  logic [SW_W-1:0]   switches,
    output logic              stall,
    output logic              in_valid,
    output logic [SW_W-1:0]   in_data,
    output logic [DATA_W-1:0] display,
    output logic              display_valid,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StWaitPress   = 3'd1,
        StWaitRelease = 3'd2,
        StCommit      = 3'd3,
        StPrint       = 3'd4
    } state_e;

    state_e      state_q;
    logic        sync1_q, sync2_q;
    logic        enter_db_q, enter_db_prev_q;
    logic [15:0] db_cnt_q;
    logic [7:0]  print_cnt_q;
    logic        press;

    // Synchronizer plus debounce: enter_db only follows enter_s after it has held steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            enter_db_q      <= 1'b0;
            enter_db_prev_q <= 1'b0;
            db_cnt_q        <= '0;
        end else begin
            sync1_q         <= enter;
            sync2_q         <= sync1_q;
            enter_db_prev_q <= enter_db_q;
            if (sync2_q != enter_db_q) begin
                if (db_cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
                    enter_db_q <= sync2_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 16'd1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Edge detect means a button already held when IN arrives never counts as a press.
    assign press = enter_db_q & ~enter_db_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            in_data       <= '0;
            display       <= '0;
            display_valid <= 1'b0;
            print_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_req) begin
                        state_q <= StWaitPress;
                    end else if (print_req) begin
                        state_q       <= StPrint;
                        display       <= print_value;
                        display_valid <= 1'b1;
                        print_cnt_q   <= 8'(PRINT_STALL - 1);
                    end
                end
                StWaitPress: begin
                    if (press) begin
                        in_data <= switches;
                        state_q <= StWaitRelease;
                    end
                end
                StWaitRelease: begin
                    if (!enter_db_q) state_q <= StCommit;
                end
                StCommit: state_q <= StIdle;
                StPrint: begin
                    if (print_cnt_q == 8'd0) state_q <= StIdle;
                    else print_cnt_q <= print_cnt_q - 8'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            StIdle:        stall = in_req | print_req;
            StWaitPress:   stall = 1'b1;
            StWaitRelease: stall = 1'b1;
            StPrint:       stall = (print_cnt_q != 8'd0);
            default:       stall = 1'b0;
        endcase
    end

    assign in_valid = (state_q == StCommit);
    assign state    = state_q;

endmodule

// File: tb/tb_io_stall_controller.sv
// Directed bench for io_stall_controller with DEBOUNCE_CYCLES=4, PRINT_STALL=2.
module tb_io_stall_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_req;
    logic        print_req;
    logic [31:0] print_value;
    logic        enter;
    logic [3:0]  switches;
    logic        stall;
    logic        in_valid;
    logic [3:0]  in_data;
    logic [31:0] display;
    logic        display_valid;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fails  = 0;
    int n;

    io_stall_controller #(
        .DEBOUNCE_CYCLES(4),
        .PRINT_STALL(2),
        .DATA_W(32),
        .SW_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_req(in_req),
        .print_req(print_req),
        .print_value(print_value),
        .enter(enter),
        .switches(switches),
        .stall(stall),
        .in_valid(in_valid),
        .in_data(in_data),
        .display(display),
        .display_valid(display_valid),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until state reaches target or max ticks elapse; n returns ticks taken.
    task automatic wait_state(input logic [2:0] target, input int max, output int cnt);
        cnt = 0;
        while (state !== target && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic start_in();
        in_req = 1'b1;
        #1;
        chk("in_stall_immediate", stall, 1);
        tick();
        in_req = 1'b0;
        chk("in_state_wait_press", state, 1);
    endtask

    task automatic press_release(input logic [3:0] sw);
        int k;
        switches = sw;
        enter    = 1'b1;
        wait_state(3'd2, 20, k);
        chk("pr_state_wait_release", state, 2);
        chk("pr_in_data", in_data, sw);
        repeat (3) tick();
        enter = 1'b0;
        wait_state(3'd3, 20, k);
        chk("pr_state_commit", state, 3);
        chk("pr_in_valid", in_valid, 1);
        chk("pr_commit_stall", stall, 0);
        chk("pr_commit_in_data", in_data, sw);
        tick();
        chk("pr_back_idle", state, 0);
        chk("pr_in_valid_drop", in_valid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        in_req      = 1'b0;
        print_req   = 1'b0;
        print_value = 32'h0;
        enter       = 1'b0;
        switches    = 4'h0;
        repeat (3) tick();
        reset = 1'b0;

        // 1. idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_stall", stall, 0);
            chk("idle_in_valid", in_valid, 0);
            chk("idle_display", display, 0);
            chk("idle_state", state, 0);
        end
        chk("idle_display_valid", display_valid, 0);
        chk("idle_in_data", in_data, 0);

        // 2. IN flow: 2 sync + 4 debounce + 1 FSM edge = 7 ticks each way
        switches = 4'hA;
        start_in();
        enter = 1'b1;
        wait_state(3'd2, 20, n);
        chk("press_latency", n, 7);
        chk("in_data_captured", in_data, 4'hA);
        chk("wait_release_stall", stall, 1);
        switches = 4'h3;
        repeat (3) tick();
        chk("in_data_held", in_data, 4'hA);
        chk("still_wait_release", state, 2);
        enter = 1'b0;
        wait_state(3'd3, 20, n);
        chk("release_latency", n, 7);
        chk("commit_in_valid", in_valid, 1);
        chk("commit_stall", stall, 0);
        tick();
        chk("after_commit_state", state, 0);
        chk("after_commit_in_valid", in_valid, 0);
        chk("after_commit_in_data", in_data, 4'hA);

        // 3. bounce shorter than the debounce window
        switches = 4'hC;
        start_in();
        enter = 1'b1; repeat (3) tick();
        enter = 1'b0; repeat (2) tick();
        enter = 1'b1; repeat (3) tick();
        enter = 1'b0; repeat (10) tick();
        chk("bounce_state", state, 1);
        chk("bounce_stall", stall, 1);
        chk("bounce_no_capture", in_data, 4'hA);
        press_release(4'h9);

        // 4. button held before IN arrives
        enter = 1'b1;
        repeat (10) tick();
        switches = 4'hE;
        start_in();
        repeat (10) tick();
        chk("held_no_capture_state", state, 1);
        chk("held_no_capture_data", in_data, 4'h9);
        enter = 1'b0;
        repeat (10) tick();
        chk("held_released_state", state, 1);
        press_release(4'h5);

        // 5. PRINT: stall 1, 1, 0
        print_req   = 1'b1;
        print_value = 32'hDEADBEEF;
        #1;
        chk("print_stall_c1", stall, 1);
        tick();
        print_req = 1'b0;
        chk("print_state", state, 4);
        chk("print_stall_c2", stall, 1);
        chk("print_display", display, 32'hDEADBEEF);
        chk("print_display_valid", display_valid, 1);
        tick();
        chk("print_state_c3", state, 4);
        chk("print_stall_c3", stall, 0);
        tick();
        chk("print_done_state", state, 0);
        chk("print_done_stall", stall, 0);

        print_req   = 1'b1;
        in_req      = 1'b1;
        print_value = 32'h12345678;
        #1;
        chk("both_stall", stall, 1);
        tick();
        print_req = 1'b0;
        in_req    = 1'b0;
        chk("both_in_priority", state, 1);
        chk("both_display_kept", display, 32'hDEADBEEF);
        press_release(4'h7);
        chk("display_after_in", display, 32'hDEADBEEF);

        // 6. reset while in WAIT_RELEASE
        switches = 4'hB;
        start_in();
        enter = 1'b1;
        wait_state(3'd2, 20, n);
        chk("rst_pre_state", state, 2);
        chk("rst_pre_in_data", in_data, 4'hB);
        enter = 1'b0;
        repeat (3) tick();
        chk("rst_pre_still_wait", state, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_stall", stall, 0);
        chk("rst_display", display, 0);
        chk("rst_display_valid", display_valid, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_in_valid", in_valid, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_in_valid", in_valid, 0);
            chk("post_rst_state", state, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
